bin_bcd_ctrl: RTL and testbench

Sequencing controller for the binary-to-BCD display path. It accepts a 32-bit binary value through a start/ready handshake and runs an iterative shift-add-3 (double-dabble) conversion, one bit per clock, into an 8-digit packed BCD result register. It then time-multiplexes that result onto an 8-digit common-anode seven-segment scan interface. The block sits between the core's memory-mapped display register and the segment decoder, and replaces free-running combinational conversion with a handshaked, single-shared-datapath converter.

---
 rtl/bin_bcd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bin_bcd_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_ctrl.sv
// Handshaked 32-bit binary to 8-digit BCD converter (one double-dabble step per clock)
// with a multiplexed, leading-zero-blanked seven-segment digit scan.
module bin_bcd_ctrl #(
   parameter int BIN_W    = 32,
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic [3:0]            seg_digit,
   output logic [DIGITS-1:0]     an,
   output logic                  dbg_state
);

   localparam int RES_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
   localparam logic [PW-1:0]    PMAX     = PW'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [RES_W-1:0] SAT      = {DIGITS{4'h9}};

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [BIN_W-1:0] shreg;
   logic [RES_W-1:0] scratch;
   logic             ovf_acc;
   logic [CNT_W-1:0] cnt;
   logic             last_step;

   logic [RES_W-1:0] adj;
   logic [RES_W-1:0] step_scr;
   logic [BIN_W-1:0] step_shreg;
   logic             step_out;
   logic             step_ovf;

   logic [PW-1:0]    presc;
   logic             presc_wrap;
   logic [IDX_W-1:0] idx;
   logic [DIGITS-1:0] upper_zero;
   logic             zero_run;
   logic             blank;

   assign last_step = (cnt == CNT_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = SHIFT;
         SHIFT:   if (last_step) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ready     = (state == IDLE);
      busy      = (state == SHIFT);
      dbg_state = state;
   end

   // One conversion step: add-3 on every nibble >= 5 (no inter-nibble carry), then shift.
   always_comb begin
      adj = scratch;
      for (int k = 0; k < DIGITS; k++) begin
         if (scratch[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
         end
      end
      {step_out, step_scr, step_shreg} = {adj, shreg, 1'b0};
      step_ovf = ovf_acc | step_out;
   end

   // Result registers only change on the final step, so the display never shows partials.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         scratch  <= '0;
         ovf_acc  <= 1'b0;
         cnt      <= '0;
         bcd      <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               shreg   <= bin;
               scratch <= '0;
               ovf_acc <= 1'b0;
               cnt     <= '0;
            end
         end else begin
            shreg   <= step_shreg;
            scratch <= step_scr;
            ovf_acc <= step_ovf;
            cnt     <= cnt + 1'b1;
            if (last_step) begin
               bcd      <= step_ovf ? SAT : step_scr;
               overflow <= step_ovf;
               done     <= 1'b1;
            end
         end
      end
   end

   // ---------------- Scan prescaler and digit index ----------------
   assign presc_wrap = (presc == PMAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc_wrap) begin
         presc <= '0;
         idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // upper_zero[k] is set when digits k..DIGITS-1 are all zero.
   always_comb begin
      zero_run   = 1'b1;
      upper_zero = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run      = zero_run & (bcd[4*k +: 4] == 4'd0);
         upper_zero[k] = zero_run;
      end
      blank = (idx != '0) && upper_zero[idx];
   end

   always_comb begin
      seg_digit = blank ? 4'd0 : bcd[4*idx +: 4];
      an        = blank ? '1 : ~(DIGITS'(1) << idx);
   end

endmodule

// File: tb/tb_bin_bcd_ctrl.sv
// Directed bench for bin_bcd_ctrl: table of conversions checked through an
// expected-result queue, plus reset, handshake and scan sequences.
module tb_bin_bcd_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] bin;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] bcd;
   logic        overflow;
   logic [3:0]  seg_digit;
   logic [7:0]  an;
   logic        dbg_state;

   int tests;
   int fails;

   logic [32:0] exp_q[$];

   typedef struct {
      logic [31:0] bin;
      logic [31:0] exp_bcd;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[12];

   bin_bcd_ctrl #(
      .BIN_W   (32),
      .DIGITS  (8),
      .SCAN_DIV(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bin      (bin),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .overflow (overflow),
      .seg_digit(seg_digit),
      .an       (an),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard: every done pops one expected result ----------------
   logic prev_done;
   initial prev_done = 1'b0;

   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 with bcd=%h expected no done", bcd);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("result_bcd", bcd, e[31:0]);
            chk("result_ovf", {31'd0, overflow}, {31'd0, e[32]});
         end
         if (busy) begin
            tests++;
            fails++;
            $display("FAIL done_with_busy: got busy=1 expected 0");
         end
         if (prev_done) begin
            tests++;
            fails++;
            $display("FAIL done_width: got done high 2 cycles expected 1");
         end
      end
      prev_done = done;
   end

   // Accept one conversion, scramble bin while busy, and check latency/busy length.
   task automatic run_conv(input logic [31:0] v, input logic [31:0] eb, input logic eo);
      int lat;
      int busy_cnt;
      @(negedge clk);
      exp_q.push_back({eo, eb});
      chk("ready_before", {31'd0, ready}, 32'd1);
      start = 1'b1;
      bin   = v;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         bin = $urandom_range(32'hFFFF_FFFF, 0);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, 32);
      chk("busy_cycles", busy_cnt, 32);
      chk("ready_at_done", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      logic [7:0] exp_an[8];
      logic [3:0] exp_seg[8];
      logic [7:0] prev_an;
      int         lat;
      int         fe_cnt;
      bit         synced;

      tests = 0;
      fails = 0;
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;

      vecs[0]  = '{32'd4,         32'h0000_0004, 1'b0};
      vecs[1]  = '{32'd6,         32'h0000_0006, 1'b0};
      vecs[2]  = '{32'd5,         32'h0000_0005, 1'b0};
      vecs[3]  = '{32'd10,        32'h0000_0010, 1'b0};
      vecs[4]  = '{32'd12,        32'h0000_0012, 1'b0};
      vecs[5]  = '{32'd14,        32'h0000_0014, 1'b0};
      vecs[6]  = '{32'd485,       32'h0000_0485, 1'b0};
      vecs[7]  = '{32'd0,         32'h0000_0000, 1'b0};
      vecs[8]  = '{32'd12345678,  32'h1234_5678, 1'b0};
      vecs[9]  = '{32'd99999999,  32'h9999_9999, 1'b0};
      vecs[10] = '{32'd100000000, 32'h9999_9999, 1'b1};
      vecs[11] = '{32'hFFFF_FFFF, 32'h9999_9999, 1'b1};

      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_bcd", bcd, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_an", {24'd0, an}, 32'h0000_00FE);
      chk("rst_seg", {28'd0, seg_digit}, 32'd0);
      rst = 1'b0;

      // ---------------- table of conversions ----------------
      for (int i = 0; i < 12; i++) begin
         run_conv(vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf);
      end

      // ---------------- reset mid-conversion ----------------
      @(negedge clk);
      start = 1'b1;
      bin   = 32'd485;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", {31'd0, ready}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_bcd", bcd, 32'd0);
      chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
      chk("mid_rst_an", {24'd0, an}, 32'h0000_00FE);
      chk("mid_rst_seg", {28'd0, seg_digit}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_rst_bcd", bcd, 32'd0);

      // ---------------- start ignored while busy; start in done cycle accepted ----------------
      @(negedge clk);
      exp_q.push_back({1'b0, 32'h0000_0485});
      start = 1'b1;
      bin   = 32'd485;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1;
      bin   = 32'd12;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("hs_first_done", {31'd0, done}, 32'd1);
      exp_q.push_back({1'b0, 32'h0000_0014});
      start = 1'b1;
      bin   = 32'd14;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         chk("hs_bcd_hold", bcd, 32'h0000_0485);
         @(negedge clk);
         lat++;
      end
      chk("hs_b2b_latency", lat, 32);

      // ---------------- scan of 485 ----------------
      run_conv(32'd485, 32'h0000_0485, 1'b0);
      exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp_seg = '{4'h5, 4'h8, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      synced = 1'b0;
      prev_an = an;
      for (int c = 0; c < 100 && !synced; c++) begin
         @(negedge clk);
         if (prev_an == 8'hFF && an == 8'hFE) synced = 1'b1;
         prev_an = an;
      end
      chk("scan_sync", {31'd0, synced}, 32'd1);
      for (int c = 0; c < 32; c++) begin
         chk("scan_an", {24'd0, an}, {24'd0, exp_an[c/4]});
         chk("scan_seg", {28'd0, seg_digit}, {28'd0, exp_seg[c/4]});
         @(negedge clk);
      end
      chk("scan_wrap_an", {24'd0, an}, 32'h0000_00FE);

      // ---------------- scan of zero: only digit 0 lit ----------------
      run_conv(32'd0, 32'd0, 1'b0);
      fe_cnt = 0;
      for (int c = 0; c < 32; c++) begin
         if (an == 8'hFE) fe_cnt++;
         else chk("zero_scan_an", {24'd0, an}, 32'h0000_00FF);
         chk("zero_scan_seg", {28'd0, seg_digit}, 32'd0);
         @(negedge clk);
      end
      chk("zero_scan_fe_cycles", fe_cnt, 4);

      repeat (2) @(negedge clk);
      chk("pending_results", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
